// File: rtl/spi_flash_pkg.sv
// Package spi_flash_pkg
// Shared by the SPI flash responder and the on-chip SPI flash master.
// Contents:
//   - opcode constants (READ 0x03, FAST_READ 0x0B)
//   - responder state enum
//   - per-phase bit counts
//   - helper functions for opcode acceptance and phase length
package spi_flash_pkg;

  localparam logic [7:0] SPI_OP_READ      = 8'h03;
  localparam logic [7:0] SPI_OP_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  // True when the opcode starts a read this build understands.
  function automatic logic op_supported(input logic [7:0] op, input logic fast_en);
    return (op == SPI_OP_READ) || (fast_en && (op == SPI_OP_FAST_READ));
  endfunction

  // Number of SCLK rises that make up one unit of the given phase.
  // In DATA this is the byte length, used to time the prefetch.
  function automatic int phase_bits(input state_t s);
    case (s)
      CMD:     return CMD_BITS;
      ADDR:    return ADDR_BITS;
      DUMMY:   return DUMMY_BITS;
      DATA:    return 8;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Module spi_sync_edge
// Brings the asynchronous SPI pins into the clk domain and derives edge pulses.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   spi_cs/sclk/mosi   raw pins
//   cs_s, mosi_s       synchronized chip select / data
//   sclk_rise/fall     one-cycle pulses from the last two synchronized SCLK samples
//   cs_rise            one-cycle pulse when synchronized CS goes high
module spi_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_cs,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic cs_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise
);

  logic [SYNC_STG-1:0] cs_sync_reg;
  logic [SYNC_STG-1:0] sclk_sync_reg;
  logic [SYNC_STG-1:0] mosi_sync_reg;
  logic                sclk_prev_reg;
  logic                cs_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      // CS resets deasserted so a reset release cannot look like a frame edge.
      cs_sync_reg   <= '1;
      sclk_sync_reg <= '0;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
    end else begin
      cs_sync_reg   <= {cs_sync_reg[SYNC_STG-2:0], spi_cs};
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STG-2:0], spi_sclk};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STG-2:0], spi_mosi};
      sclk_prev_reg <= sclk_sync_reg[SYNC_STG-1];
      cs_prev_reg   <= cs_sync_reg[SYNC_STG-1];
    end
  end

  assign cs_s      = cs_sync_reg[SYNC_STG-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STG-1];
  assign sclk_rise = sclk_sync_reg[SYNC_STG-1] & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_sync_reg[SYNC_STG-1] & sclk_prev_reg;
  assign cs_rise   = cs_sync_reg[SYNC_STG-1] & ~cs_prev_reg;

endmodule

// File: rtl/spi_flash_responder.sv
// Module spi_flash_responder
// SPI mode-0 flash target answering the READ (0x03) command from an internal byte RAM.
// Optional build macro SPI_RESP_FAST_READ_EN adds FAST_READ (0x0B) with 8 dummy clocks.
// Ports:
//   clk, rst                system clock, synchronous active-high reset
//   spi_cs/sclk/mosi        SPI inputs (oversampled; SCLK half-period >= SYNC_STG+3 clk)
//   spi_miso, spi_miso_oe   serial output and pad enable (high only in DATA)
//   load_we/addr/wdata      RAM preload port, dropped while busy
//   busy                    frame in progress (synchronized CS low)
//   cmd_err                 one-cycle pulse on an unsupported opcode
// ADDR_W must be >= 8 (the shift register doubles as opcode capture).
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_wdata,
  output logic              busy,
  output logic              cmd_err
);

`ifdef SPI_RESP_FAST_READ_EN
  localparam logic FAST_EN = 1'b1;
`else
  localparam logic FAST_EN = 1'b0;
`endif

  // Only the low ADDR_W-1 bits of history are needed: with the live MOSI bit
  // they form the RAM index, and the low 7 form the opcode.
  localparam int SH_W = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise;

  spi_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .spi_cs    (spi_cs),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .cs_s      (cs_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_rise   (cs_rise)
  );

  state_t            state_reg, state_next;
  logic [4:0]        cnt_reg, cnt_next;      // rises within current phase
  logic [2:0]        ocnt_reg, ocnt_next;    // falls within current data byte
  logic [SH_W-1:0]   shift_reg, shift_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;    // next byte to prefetch
  logic [7:0]        out_reg, out_next;
  logic              miso_reg, miso_next;
  logic              oe_reg, oe_next;
  logic              busy_reg;
  logic              err_reg, err_next;
  logic              last_bit;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] addr_in;
  logic [7:0]        opcode_in;
  logic [7:0]        rd_data_reg;
`ifdef SPI_RESP_FAST_READ_EN
  logic              fast_reg, fast_next;
`endif

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  // Values as they will be once the current rise's MOSI bit is shifted in.
  assign opcode_in = {shift_reg[6:0], mosi_s};
  assign addr_in   = {shift_reg, mosi_s};
  assign last_bit  = (cnt_reg == 5'(phase_bits(state_reg) - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ocnt_next  = ocnt_reg;
    shift_next = shift_reg;
    addr_next  = addr_reg;
    out_next   = out_reg;
    miso_next  = miso_reg;
    oe_next    = oe_reg;
    err_next   = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = addr_reg;
`ifdef SPI_RESP_FAST_READ_EN
    fast_next  = fast_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (!cs_s) begin
          state_next = CMD;
          cnt_next   = '0;
        end
      end

      CMD: begin
        if (sclk_rise) begin
          shift_next = {shift_reg[SH_W-2:0], mosi_s};
          cnt_next   = cnt_reg + 5'd1;
          if (last_bit) begin
            cnt_next = '0;
            if (op_supported(opcode_in, FAST_EN)) begin
              state_next = ADDR;
`ifdef SPI_RESP_FAST_READ_EN
              fast_next  = (opcode_in == SPI_OP_FAST_READ);
`endif
            end else begin
              state_next = IGNORE;
              err_next   = 1'b1;
            end
          end
        end
      end

      ADDR: begin
        if (sclk_rise) begin
          shift_next = {shift_reg[SH_W-2:0], mosi_s};
          cnt_next   = cnt_reg + 5'd1;
          if (last_bit) begin
            cnt_next = '0;
`ifdef SPI_RESP_FAST_READ_EN
            if (fast_reg) begin
              state_next = DUMMY;
              addr_next  = addr_in;
            end else
`endif
            begin
              // Fetch the first byte now; it is registered long before the next fall.
              rd_en      = 1'b1;
              rd_addr    = addr_in;
              addr_next  = addr_in + ADDR_ONE;
              state_next = DATA;
              oe_next    = 1'b1;
              ocnt_next  = '0;
            end
          end
        end
      end

`ifdef SPI_RESP_FAST_READ_EN
      DUMMY: begin
        if (sclk_rise) begin
          cnt_next = cnt_reg + 5'd1;
          if (last_bit) begin
            cnt_next   = '0;
            rd_en      = 1'b1;
            addr_next  = addr_reg + ADDR_ONE;
            state_next = DATA;
            oe_next    = 1'b1;
            ocnt_next  = '0;
          end
        end
      end
`endif

      DATA: begin
        if (sclk_fall) begin
          // First fall of a byte takes bit7 straight from the prefetched RAM word.
          if (ocnt_reg == 3'd0) begin
            miso_next = rd_data_reg[7];
            out_next  = {rd_data_reg[6:0], 1'b0};
          end else begin
            miso_next = out_reg[7];
            out_next  = {out_reg[6:0], 1'b0};
          end
          ocnt_next = ocnt_reg + 3'd1;
        end
        if (sclk_rise) begin
          cnt_next = cnt_reg + 5'd1;
          if (last_bit) begin
            // Bit0 already shifted out: refill the RAM word for the next byte.
            cnt_next  = '0;
            rd_en     = 1'b1;
            addr_next = addr_reg + ADDR_ONE;
          end
        end
      end

      default: ;  // IGNORE holds until CS rises
    endcase

    // CS deassertion aborts any phase; nothing of the partial frame survives.
    if (cs_rise) begin
      state_next = IDLE;
      cnt_next   = '0;
      ocnt_next  = '0;
      shift_next = '0;
      miso_next  = 1'b0;
      oe_next    = 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
      fast_next  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ocnt_reg  <= '0;
      shift_reg <= '0;
      addr_reg  <= '0;
      out_reg   <= '0;
      miso_reg  <= 1'b0;
      oe_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
      fast_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ocnt_reg  <= ocnt_next;
      shift_reg <= shift_next;
      addr_reg  <= addr_next;
      out_reg   <= out_next;
      miso_reg  <= miso_next;
      oe_reg    <= oe_next;
      busy_reg  <= (state_next != IDLE);
      err_reg   <= err_next;
`ifdef SPI_RESP_FAST_READ_EN
      fast_reg  <= fast_next;
`endif
    end
  end

  // Reads only happen while busy, so the busy gate keeps the two ports disjoint.
  always_ff @(posedge clk) begin
    if (load_we && !busy_reg) begin
      mem[load_addr] <= load_wdata;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign spi_miso    = miso_reg;
  assign spi_miso_oe = oe_reg;
  assign busy        = busy_reg;
  assign cmd_err     = err_reg;

endmodule
